muldiv_control_unit: RTL and testbench
======================================

# muldiv_control_unit

Hardwired control sequencer driving the datapath's control inputs for instruction fetch followed by `mul`/`div` execution. It replaces stimulus-driven control with a Moore FSM.
- Reads the opcode and register fields from `IR_Data`.
- Steps through the seven-step sequence T0–T6, asserting the matching register enables, bus-encoder selects, memory read strobe and ALU opcode each step.
- Sits between the top level and the `datapath` module; its outputs connect one-to-one to the datapath's same-named inputs.

## Interface
- `MUL_OPCODE`, default 5'b01111: IR[31:27] value for `mul`.
- `DIV_OPCODE`, default 5'b10000: IR[31:27] value for `div`.
- `clk` input 1: single clock, rising edge.
- `clear_n` input 1: asynchronous, active-low reset.
- `run` input 1: sequencer advances only while high.
- `IR_Data` input 32: current IR contents; [31:27] opcode, [26:23] Ra, [22:19] Rb.
- `PC_select`, `MAR_enable`, `PC_increment_enable`, `Z_enable` output 1 each: T0 controls.
- `Z_LO_select`, `PC_enable`, `read`, `MDR_enable` output 1 each: T1 controls (`Z_LO_select` is also used in T5).
- `MDR_select`, `IR_enable` output 1 each: T2 controls.
- `reg_select` output 16: one-hot general-register bus select (bit n drives Rn onto the bus).
- `Y_enable` output 1: T3 control.
- `alu_instruction` output 5: ALU opcode, valid in T4 only.
- `LO_enable`, `Z_HI_select`, `HI_enable` output 1 each: T5/T6 controls.
- `done` output 1: one-cycle pulse in T6.
- `illegal_op` output 1: one-cycle pulse when the decoded opcode is unsupported.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Each state lasts exactly one clock while `run`=1.
- Outputs are a pure decode of the state (Moore). Only the signals listed for a state are 1; all others are 0.
- IDLE: all outputs 0.
  - `run`=1 → T0.
- T0: `PC_select`, `MAR_enable`, `PC_increment_enable`, `Z_enable`.
- T1: `Z_LO_select`, `PC_enable`, `read`, `MDR_enable`.
- T2: `MDR_select`, `IR_enable`. IR loads at the end of T2.
- T3: `reg_select` = one-hot(IR_Data[26:23]), `Y_enable`.
  - On leaving T3, latch `op_q`=IR[31:27] and `rb_q`=IR[22:19].
  - If the opcode is supported → T4.
  - Otherwise `illegal_op`=1 during T3 and the next state is T0 (`run`=1) or IDLE (`run`=0); `Y_enable` is still asserted.
- T4: `reg_select` = one-hot(`rb_q`), `Z_enable`, `alu_instruction`=`op_q`.
- T5: `Z_LO_select`, `LO_enable`.
- T6: `Z_HI_select`, `HI_enable`, `done`.
  - `run`=1 → T0; `run`=0 → IDLE.
- `run`=0 in T0–T5:
  - State holds.
  - All outputs forced to 0, so no repeated enables occur.
  - Resumes in the same state when `run` returns high.
- `reg_select` is all-zero in every state except T3 and T4.
- Ra and Rb may be equal. Both select the same bit; no special handling.

## Timing
- Reset (`clear_n` low, asynchronous, including mid-sequence):
  - State = IDLE.
  - `op_q`/`rb_q` = 0.
  - Every output is 0 within the same cycle, without waiting for a clock edge.
- After `clear_n` rises, the first T0 is entered on the first rising edge where `run`=1.
- Full instruction latency: 7 clocks, T0 through T6, with `done` in the 7th.
- With `run` held high, back-to-back instructions have zero idle cycles: T6 → T0.
- `IR_Data` is sampled only during T3. Changes in other states have no effect.
- Unsupported opcode costs 4 clocks (T0–T3) before the next fetch.

## Configuration
- `MULDIV_DIV_EN` defined: `DIV_OPCODE` is supported and runs T4–T6 with `alu_instruction`=`DIV_OPCODE`.
- `MULDIV_DIV_EN` undefined: only `MUL_OPCODE` is supported. `DIV_OPCODE` is treated as illegal (`illegal_op` pulse in T3, then T0/IDLE).

## Test plan
- **mul fetch/execute.** Reset, `run`=1, `IR_Data`=32'h7B380000 from T3 onward.
  - T3: `reg_select`=16'h0040, `Y_enable`=1.
  - T4: `reg_select`=16'h0080, `alu_instruction`=5'b01111, `Z_enable`=1.
  - T5 `LO_enable`=1; T6 `HI_enable`=1, `done`=1.
  - Next cycle is T0.
- **Per-state exclusivity.** Check each of the 7 states against the exact asserted set listed in Operation. Every unlisted output is 0 in every cycle.
- **Illegal opcode.** `IR_Data`=32'h00000000 in T3.
  - `illegal_op`=1 for exactly one cycle.
  - Next state T0; no `LO_enable`/`HI_enable` ever asserted.
- **div gating.** `IR_Data`=32'h83380000 (opcode 10000).
  - With `MULDIV_DIV_EN`: T4 `alu_instruction`=5'b10000.
  - Without: `illegal_op` pulse, no T4.
- **run stall.** Drop `run` for 3 cycles during T4.
  - Outputs all 0 for those 3 cycles.
  - On resume, T4 is reasserted once, then T5 and T6 follow.
  - Total `done` count = 1.
- **Reset mid-operation.** Assert `clear_n`=0 asynchronously in T5.
  - All outputs 0 immediately; state IDLE.
  - After release with `run`=1, the first asserted signal is `PC_select` (T0).

Source files
------------

// File: rtl/muldiv_control_unit.sv
// ============================================================================
//  Module      : muldiv_control_unit
//  Description : Hardwired Moore sequencer for instruction fetch followed by
//                mul/div execution (T0..T6). It drives the datapath control
//                inputs, which share their names with these outputs.
//                Optional feature macro: MULDIV_DIV_EN. When it is defined,
//                DIV_OPCODE is accepted as a legal instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_control_unit #(
    parameter logic [4:0] MUL_OPCODE = 5'b01111,
    parameter logic [4:0] DIV_OPCODE = 5'b10000
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        run,
    input  logic [31:0] IR_Data,
    output logic        PC_select,
    output logic        MAR_enable,
    output logic        PC_increment_enable,
    output logic        Z_enable,
    output logic        Z_LO_select,
    output logic        PC_enable,
    output logic        read,
    output logic        MDR_enable,
    output logic        MDR_select,
    output logic        IR_enable,
    output logic [15:0] reg_select,
    output logic        Y_enable,
    output logic [4:0]  alu_instruction,
    output logic        LO_enable,
    output logic        Z_HI_select,
    output logic        HI_enable,
    output logic        done,
    output logic        illegal_op
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    state_t      state;
    logic [4:0]  op_q;
    logic [3:0]  rb_q;
    logic        op_supported;
    logic        drive;
    logic [15:0] one_hot_base;
    logic        unused_ir;

    // The low IR bits carry fields this sequencer never decodes
    assign unused_ir    = ^IR_Data[18:0];
    assign one_hot_base = 16'h0001;

    // Opcode legality check, used only while the FSM sits in T3
`ifdef MULDIV_DIV_EN
    assign op_supported = (IR_Data[31:27] == MUL_OPCODE) ||
                          (IR_Data[31:27] == DIV_OPCODE);
`else
    assign op_supported = (IR_Data[31:27] == MUL_OPCODE);
`endif

    // State sequencing and capture of the opcode and Rb fields on leaving T3
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
            op_q  <= 5'd0;
            rb_q  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_T0;
                S_T0:   if (run) state <= S_T1;
                S_T1:   if (run) state <= S_T2;
                S_T2:   if (run) state <= S_T3;
                S_T3: begin
                    if (run) begin
                        op_q  <= IR_Data[31:27];
                        rb_q  <= IR_Data[22:19];
                        state <= op_supported ? S_T4 : S_T0;
                    end
                end
                S_T4:   if (run) state <= S_T5;
                S_T5:   if (run) state <= S_T6;
                S_T6:   state <= run ? S_T0 : S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // T6 always completes in one clock. Every other step is silenced while
    // run is low, so no enable repeats across a stall.
    assign drive = run || (state == S_T6);

    // Moore decode of the current state into datapath control strobes
    always_comb begin
        PC_select           = 1'b0;
        MAR_enable          = 1'b0;
        PC_increment_enable = 1'b0;
        Z_enable            = 1'b0;
        Z_LO_select         = 1'b0;
        PC_enable           = 1'b0;
        read                = 1'b0;
        MDR_enable          = 1'b0;
        MDR_select          = 1'b0;
        IR_enable           = 1'b0;
        reg_select          = 16'h0000;
        Y_enable            = 1'b0;
        alu_instruction     = 5'd0;
        LO_enable           = 1'b0;
        Z_HI_select         = 1'b0;
        HI_enable           = 1'b0;
        done                = 1'b0;
        illegal_op          = 1'b0;
        if (drive) begin
            case (state)
                S_T0: begin
                    PC_select           = 1'b1;
                    MAR_enable          = 1'b1;
                    PC_increment_enable = 1'b1;
                    Z_enable            = 1'b1;
                end
                S_T1: begin
                    Z_LO_select = 1'b1;
                    PC_enable   = 1'b1;
                    read        = 1'b1;
                    MDR_enable  = 1'b1;
                end
                S_T2: begin
                    MDR_select = 1'b1;
                    IR_enable  = 1'b1;
                end
                S_T3: begin
                    reg_select = one_hot_base << IR_Data[26:23];
                    Y_enable   = 1'b1;
                    illegal_op = ~op_supported;
                end
                S_T4: begin
                    reg_select      = one_hot_base << rb_q;
                    Z_enable        = 1'b1;
                    alu_instruction = op_q;
                end
                S_T5: begin
                    Z_LO_select = 1'b1;
                    LO_enable   = 1'b1;
                end
                S_T6: begin
                    Z_HI_select = 1'b1;
                    HI_enable   = 1'b1;
                    done        = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_control_unit.sv
// ============================================================================
//  Module      : tb_muldiv_control_unit
//  Description : Directed self-checking bench for muldiv_control_unit.
//                The build may define MULDIV_DIV_EN, which selects the
//                expected behaviour for the div opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_control_unit;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        run;
    logic [31:0] IR_Data;
    logic        PC_select, MAR_enable, PC_increment_enable, Z_enable;
    logic        Z_LO_select, PC_enable, read, MDR_enable;
    logic        MDR_select, IR_enable, Y_enable;
    logic [15:0] reg_select;
    logic [4:0]  alu_instruction;
    logic        LO_enable, Z_HI_select, HI_enable, done, illegal_op;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    // Expected single-bit controls, packed MSB first:
    // PC_select MAR_enable PC_increment_enable Z_enable | Z_LO_select PC_enable read MDR_enable |
    // MDR_select IR_enable Y_enable LO_enable | Z_HI_select HI_enable done illegal_op
    logic [15:0] ctrl;
    assign ctrl = {PC_select, MAR_enable, PC_increment_enable, Z_enable,
                   Z_LO_select, PC_enable, read, MDR_enable,
                   MDR_select, IR_enable, Y_enable, LO_enable,
                   Z_HI_select, HI_enable, done, illegal_op};

    localparam logic [15:0] C_IDLE = 16'h0000;
    localparam logic [15:0] C_T0   = 16'hF000;
    localparam logic [15:0] C_T1   = 16'h0F00;
    localparam logic [15:0] C_T2   = 16'h00C0;
    localparam logic [15:0] C_T3   = 16'h0020;
    localparam logic [15:0] C_T3X  = 16'h0021;
    localparam logic [15:0] C_T4   = 16'h1000;
    localparam logic [15:0] C_T5   = 16'h0810;
    localparam logic [15:0] C_T6   = 16'h000E;

    localparam logic [31:0] IR_MUL = 32'h7B380000;
    localparam logic [31:0] IR_DIV = 32'h83380000;
    localparam logic [31:0] IR_BAD = 32'h00000000;

    muldiv_control_unit dut (
        .clk                 (clk),
        .clear_n             (clear_n),
        .run                 (run),
        .IR_Data             (IR_Data),
        .PC_select           (PC_select),
        .MAR_enable          (MAR_enable),
        .PC_increment_enable (PC_increment_enable),
        .Z_enable            (Z_enable),
        .Z_LO_select         (Z_LO_select),
        .PC_enable           (PC_enable),
        .read                (read),
        .MDR_enable          (MDR_enable),
        .MDR_select          (MDR_select),
        .IR_enable           (IR_enable),
        .reg_select          (reg_select),
        .Y_enable            (Y_enable),
        .alu_instruction     (alu_instruction),
        .LO_enable           (LO_enable),
        .Z_HI_select         (Z_HI_select),
        .HI_enable           (HI_enable),
        .done                (done),
        .illegal_op          (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [15:0] c,
                                input logic [15:0] rs, input logic [4:0] alu);
        check({tag, ".ctrl"}, {16'h0, ctrl}, {16'h0, c});
        check({tag, ".reg_select"}, {16'h0, reg_select}, {16'h0, rs});
        check({tag, ".alu"}, {27'h0, alu_instruction}, {27'h0, alu});
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
    endtask

    // T0..T2 with an IR value that must not matter outside T3
    task automatic fetch(input string tag);
        expect_state({tag, ".T0"}, C_T0, 16'h0, 5'd0);
        IR_Data = 32'hFFFF_FFFF;
        tick(); expect_state({tag, ".T1"}, C_T1, 16'h0, 5'd0);
        tick(); expect_state({tag, ".T2"}, C_T2, 16'h0, 5'd0);
        tick();
    endtask

    initial begin
        clear_n = 1'b0;
        run     = 1'b0;
        IR_Data = 32'h0;
        #3;
        expect_state("reset", C_IDLE, 16'h0, 5'd0);
        #10;
        clear_n = 1'b1;
        tick(); expect_state("idle_run0", C_IDLE, 16'h0, 5'd0);

        // mul fetch/execute
        run = 1'b1;
        tick();
        fetch("mul");
        IR_Data = IR_MUL; #1;
        expect_state("mul.T3", C_T3, 16'h0040, 5'd0);
        tick();
        IR_Data = IR_BAD; #1;
        expect_state("mul.T4", C_T4, 16'h0080, 5'b01111);
        tick(); expect_state("mul.T5", C_T5, 16'h0, 5'd0);
        tick(); expect_state("mul.T6", C_T6, 16'h0, 5'd0);
        tick();

        // Illegal opcode: single-cycle pulse, straight back to fetch
        fetch("ill");
        IR_Data = IR_BAD; #1;
        expect_state("ill.T3", C_T3X, 16'h0001, 5'd0);
        tick();

        // div: legal only when the div feature is built in
        fetch("div");
        IR_Data = IR_DIV; #1;
`ifdef MULDIV_DIV_EN
        expect_state("div.T3", C_T3, 16'h0040, 5'd0);
        tick(); expect_state("div.T4", C_T4, 16'h0080, 5'b10000);
        tick(); expect_state("div.T5", C_T5, 16'h0, 5'd0);
        tick(); expect_state("div.T6", C_T6, 16'h0, 5'd0);
        tick();
`else
        expect_state("div.T3", C_T3X, 16'h0040, 5'd0);
        tick();
`endif

        // run stall inside T4
        fetch("stall");
        IR_Data = IR_MUL; #1;
        expect_state("stall.T3", C_T3, 16'h0040, 5'd0);
        tick();
        done_cnt = 0;
        expect_state("stall.T4", C_T4, 16'h0080, 5'b01111);
        run = 1'b0; #1;
        expect_state("stall.hold1", C_IDLE, 16'h0, 5'd0);
        tick(); expect_state("stall.hold2", C_IDLE, 16'h0, 5'd0);
        tick(); expect_state("stall.hold3", C_IDLE, 16'h0, 5'd0);
        run = 1'b1; #1;
        expect_state("stall.T4again", C_T4, 16'h0080, 5'b01111);
        tick(); expect_state("stall.T5", C_T5, 16'h0, 5'd0);
        tick(); expect_state("stall.T6", C_T6, 16'h0, 5'd0);
        run = 1'b0;
        tick(); expect_state("stall.idle", C_IDLE, 16'h0, 5'd0);
        tick();
        check("stall.done_count", done_cnt, 1);

        // Asynchronous reset during T5
        run = 1'b1;
        tick();
        fetch("rst");
        IR_Data = IR_MUL;
        tick(); tick();
        expect_state("rst.T5", C_T5, 16'h0, 5'd0);
        #2;
        clear_n = 1'b0; #1;
        expect_state("rst.async", C_IDLE, 16'h0, 5'd0);
        tick(); expect_state("rst.held", C_IDLE, 16'h0, 5'd0);
        clear_n = 1'b1;
        tick(); expect_state("rst.first_T0", C_T0, 16'h0, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
